// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and FSM state type for the register file slice
//   XLEN_DEF   default register width
//   NREG_DEF   default register count
//   rf_state_t IDLE (accepting traffic) / CLEAR (sweeping registers to zero)
package regfile_pkg;
    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    typedef enum logic {IDLE, CLEAR} rf_state_t;
endpackage

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: per-read-port x0 zeroing, write-back forwarding and busy masking
//   addr     register being read
//   rf_data  array contents at addr
//   rf_busy  scoreboard bit at addr
//   fwd_en   a write-back is being accepted this cycle
//   wb_rd    write-back destination
//   wb_data  write-back data
//   data     resolved read data
//   busy     resolved busy flag
module regfile_bypass_mux #(
    parameter int XLEN = 64,
    parameter int AW = 5,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            rf_busy,
    input  logic            fwd_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            busy
);
    logic zero;
    logic hit;
    always_comb begin
        zero = addr == '0;
        hit  = (BYPASS != 0) && fwd_en && (wb_rd == addr) && !zero;
        data = zero ? '0 : hit ? wb_data : rf_data;
        // the producer is retiring this very cycle, so the value is already available
        busy = !zero && !hit && rf_busy;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-ported register file with busy scoreboard and soft-clear sweep
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   rs1_addr, rs2_addr  read addresses
//   rs1_data, rs2_data  combinational read data (x0 reads zero, optional forwarding)
//   rs1_busy, rs2_busy  outstanding-producer flags for the read registers
//   iss_valid, iss_rd   issue: mark iss_rd busy
//   wb_valid, wb_rd,
//   wb_data             write-back: write register and retire its busy flag
//   clr_req             start sweeping all registers to zero
//   ready               high when idle and accepting issue/write-back
//   debug               low 16 bits of register DEBUG_REG
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int BYPASS = 1,
    parameter int DEBUG_REG = 31,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            clr_req,
    output logic            ready,
    output logic [15:0]     debug
);
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);
    localparam logic [AW-1:0] DBG = AW'(DEBUG_REG);

    rf_state_t state, state_nxt;
    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] busy;
    logic [AW-1:0] idx;
    logic fwd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb state_nxt = (state == IDLE) ? (clr_req ? CLEAR : IDLE) : (idx == LAST ? IDLE : CLEAR);

    always_comb begin
        ready  = state == IDLE;
        fwd_en = ready && wb_valid;
    end

    // x0 is never written, so it stays zero without a special read path here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            busy <= '0;
            idx  <= '0;
        end else if (ready) begin
            if (wb_valid && wb_rd != '0) rf[wb_rd] <= wb_data;
            if (clr_req) begin
                busy <= '0;
                idx  <= AW'(1);
            end else begin
                if (wb_valid) busy[wb_rd] <= 1'b0;
                // issue is applied after retire so a new producer wins on the same rd
                if (iss_valid && iss_rd != '0) busy[iss_rd] <= 1'b1;
            end
        end else begin
            rf[idx] <= '0;
            idx <= (idx == LAST) ? idx : idx + AW'(1);
        end
    end

    regfile_bypass_mux #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rs1 (
        .addr(rs1_addr), .rf_data(rf[rs1_addr]), .rf_busy(busy[rs1_addr]), .fwd_en(fwd_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .data(rs1_data), .busy(rs1_busy)
    );

    regfile_bypass_mux #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rs2 (
        .addr(rs2_addr), .rf_data(rf[rs2_addr]), .rf_busy(busy[rs2_addr]), .fwd_en(fwd_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .data(rs2_data), .busy(rs2_busy)
    );

    assign debug = rf[DBG][15:0];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench for regfile_scoreboard in three configurations
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_addr, rs2_addr, iss_rd, wb_rd;
    logic [63:0] wb_data;
    logic iss_valid, wb_valid, clr_req;
    logic [63:0] rs1_a, rs2_a, rs1_b, rs2_b;
    logic b1_a, b2_a, b1_b, b2_b, ready_a, ready_b;
    logic [15:0] dbg_a, dbg_b;
    logic [3:0] c_rs1_addr, c_rs2_addr, c_iss_rd, c_wb_rd;
    logic [31:0] c_wb_data, c_rs1, c_rs2;
    logic c_iss_valid, c_wb_valid, c_clr_req, c_b1, c_b2, c_ready;
    logic [15:0] c_dbg;
    int n_cmp = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    regfile_scoreboard dut_a (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_a), .rs2_data(rs2_a),
        .rs1_busy(b1_a), .rs2_busy(b2_a), .iss_valid(iss_valid), .iss_rd(iss_rd), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .clr_req(clr_req), .ready(ready_a), .debug(dbg_a)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_b), .rs2_data(rs2_b),
        .rs1_busy(b1_b), .rs2_busy(b2_b), .iss_valid(iss_valid), .iss_rd(iss_rd), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .clr_req(clr_req), .ready(ready_b), .debug(dbg_b)
    );

    regfile_scoreboard #(.XLEN(32), .NREG(16), .DEBUG_REG(15)) dut_c (
        .clk(clk), .rst(rst), .rs1_addr(c_rs1_addr), .rs2_addr(c_rs2_addr), .rs1_data(c_rs1), .rs2_data(c_rs2),
        .rs1_busy(c_b1), .rs2_busy(c_b2), .iss_valid(c_iss_valid), .iss_rd(c_iss_rd), .wb_valid(c_wb_valid),
        .wb_rd(c_wb_rd), .wb_data(c_wb_data), .clr_req(c_clr_req), .ready(c_ready), .debug(c_dbg)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a();
        for (int i = 1; i < 32; i++) begin
            wb_valid = 1'b1;
            wb_rd = 5'(i);
            wb_data = 64'(i);
            tick();
        end
        wb_valid = 1'b0;
    endtask

    task automatic fill_c();
        for (int i = 1; i < 16; i++) begin
            c_wb_valid = 1'b1;
            c_wb_rd = 4'(i);
            c_wb_data = 32'h100 + 32'(i);
            tick();
        end
        c_wb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {rs1_addr, rs2_addr, iss_rd, wb_rd, wb_data, iss_valid, wb_valid, clr_req} = '0;
        {c_rs1_addr, c_rs2_addr, c_iss_rd, c_wb_rd, c_wb_data, c_iss_valid, c_wb_valid, c_clr_req} = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("init_ready", ready_a, 1);
        check("init_debug", dbg_a, 0);
        // write then read next cycle
        wb_valid = 1'b1; wb_rd = 5; wb_data = 64'hDEAD_BEEF;
        tick();
        wb_valid = 1'b0; rs1_addr = 5;
        #1;
        check("rd_x5_a", rs1_a, 64'hDEAD_BEEF);
        check("rd_x5_b", rs1_b, 64'hDEAD_BEEF);
        // x0 write is dropped and never forwarded
        wb_valid = 1'b1; wb_rd = 0; wb_data = 7; rs1_addr = 0;
        #1;
        check("x0_nofwd", rs1_a, 0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("x0_read", rs1_a, 0);
        // bypass on both ports
        wb_valid = 1'b1; wb_rd = 3; wb_data = 64'h1111;
        tick();
        wb_data = 64'h1234; rs1_addr = 3; rs2_addr = 3;
        #1;
        check("byp_rs1_a", rs1_a, 64'h1234);
        check("byp_rs2_a", rs2_a, 64'h1234);
        check("nobyp_rs1_b", rs1_b, 64'h1111);
        check("nobyp_rs2_b", rs2_b, 64'h1111);
        tick();
        wb_valid = 1'b0;
        #1;
        check("after_byp_a", rs1_a, 64'h1234);
        check("after_byp_b", rs2_b, 64'h1234);
        // scoreboard
        iss_valid = 1'b1; iss_rd = 7; rs2_addr = 7;
        #1;
        check("busy_pre", b2_a, 0);
        tick();
        iss_valid = 1'b0;
        #1;
        check("busy_set_a", b2_a, 1);
        check("busy_set_b", b2_b, 1);
        wb_valid = 1'b1; wb_rd = 7; wb_data = 64'h77;
        #1;
        check("busy_mask_a", b2_a, 0);
        check("busy_nomask_b", b2_b, 1);
        tick();
        wb_valid = 1'b0;
        #1;
        check("busy_clr_a", b2_a, 0);
        check("busy_clr_b", b2_b, 0);
        iss_valid = 1'b1; wb_valid = 1'b1;
        tick();
        iss_valid = 1'b0; wb_valid = 1'b0;
        #1;
        check("busy_setwins", b2_a, 1);
        // debug register
        wb_valid = 1'b1; wb_rd = 31; wb_data = 64'hABCD_5678_9ABC_DEF0;
        #1;
        check("debug_pre", dbg_a, 0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("debug_val", dbg_a, 16'hDEF0);
        // asynchronous reset mid-run
        rs1_addr = 5; rs2_addr = 7;
        rst = 1'b1;
        #1;
        check("rst_rs1", rs1_a, 0);
        check("rst_busy", b2_a, 0);
        check("rst_ready", ready_a, 1);
        check("rst_debug", dbg_a, 0);
        tick();
        rst = 1'b0;
        // full clear sweep
        fill_a();
        rs1_addr = 17;
        #1;
        check("fill_x17", rs1_a, 17);
        iss_valid = 1'b1; iss_rd = 9;
        tick();
        iss_valid = 1'b0;
        clr_req = 1'b1; wb_valid = 1'b1; wb_rd = 4; wb_data = 64'h999;
        tick();
        wb_valid = 1'b1; wb_rd = 31; wb_data = '1; iss_valid = 1'b1; iss_rd = 20;
        rs1_addr = 31; rs2_addr = 9;
        #1;
        check("clr_ready", ready_a, 0);
        check("clr_nobyp", rs1_a, 31);
        check("clr_busy0", b2_a, 0);
        n = 0;
        while (!ready_a && n < 100) begin
            n++;
            tick();
        end
        clr_req = 1'b0; wb_valid = 1'b0; iss_valid = 1'b0;
        check("clr_cycles", n, 31);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            #1;
            check($sformatf("clr_x%0d", i), rs1_a, 0);
        end
        rs2_addr = 20;
        #1;
        check("clr_noiss", b2_a, 0);
        check("clr_debug", dbg_a, 0);
        check("clr_ready_b", ready_b, 1);
        // reset on the tenth CLEAR cycle
        fill_a();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        rs1_addr = 5; rs2_addr = 20;
        #1;
        check("mid_ready", ready_a, 0);
        check("mid_x5", rs1_a, 0);
        check("mid_x20", rs2_a, 20);
        rst = 1'b1;
        #1;
        check("midrst_ready", ready_a, 1);
        check("midrst_x20", rs2_a, 0);
        check("midrst_debug", dbg_a, 0);
        tick();
        rst = 1'b0;
        // 16 x 32-bit configuration
        fill_c();
        c_rs1_addr = 15; c_rs2_addr = 1;
        #1;
        check("c_x15", c_rs1, 32'h10F);
        check("c_x1", c_rs2, 32'h101);
        check("c_debug", c_dbg, 16'h010F);
        c_iss_valid = 1'b1; c_iss_rd = 1;
        tick();
        c_iss_valid = 1'b0;
        #1;
        check("c_busy", c_b2, 1);
        c_clr_req = 1'b1;
        tick();
        c_clr_req = 1'b0;
        #1;
        check("c_busy_clr", c_b2, 0);
        n = 0;
        while (!c_ready && n < 100) begin
            n++;
            tick();
        end
        check("c_clr_cycles", n, 15);
        for (int i = 0; i < 16; i++) begin
            c_rs1_addr = 4'(i);
            #1;
            check($sformatf("c_clr_x%0d", i), c_rs1, 0);
        end
        fill_c();
        c_clr_req = 1'b1;
        tick();
        c_clr_req = 1'b0;
        repeat (9) tick();
        c_rs1_addr = 15;
        #1;
        check("c_mid_ready", c_ready, 0);
        check("c_mid_x15", c_rs1, 32'h10F);
        rst = 1'b1;
        #1;
        check("c_midrst_ready", c_ready, 1);
        check("c_midrst_x15", c_rs1, 0);
        check("c_midrst_debug", c_dbg, 0);
        tick();
        rst = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
